// File: rtl/fir_mac_sequencer_pkg.sv
// Shared widths, default parameters and FSM encoding for the time-multiplexed FIR engine.
package fir_mac_sequencer_pkg;

   localparam int DATA_W        = 16;
   localparam int PROD_W        = 32;
   localparam int DEFAULT_TAPS  = 8;
   localparam int DEFAULT_SHIFT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/fir_mac_sequencer_coef_bank.sv
// TAPS x 16-bit coefficient register file: one write port, one combinational read port.
module fir_mac_sequencer_coef_bank
   import fir_mac_sequencer_pkg::*;
#(
   parameter int TAPS = DEFAULT_TAPS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [$clog2(TAPS)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [$clog2(TAPS)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] coef_q [TAPS];
   logic [DATA_W-1:0] coef_d [TAPS];

   // Addresses beyond TAPS-1 (possible when TAPS is not a power of two) are dropped.
   always_comb begin
      coef_d = coef_q;
      if (we && (int'(waddr) < TAPS)) begin
         coef_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         coef_q <= coef_d;
      end
   end

   assign rdata = coef_q[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: circular delay line, one MAC per cycle through an external multiplier,
// then shift and saturate the accumulator into one 16-bit output.
module fir_mac_sequencer
   import fir_mac_sequencer_pkg::*;
#(
   parameter int TAPS  = DEFAULT_TAPS,
   parameter int SHIFT = DEFAULT_SHIFT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic [DATA_W-1:0]         coef_wdata,
   output logic [DATA_W-1:0]         mult_a,
   output logic [DATA_W-1:0]         mult_b,
   input  logic [PROD_W-1:0]         mult_p,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_sat
);

   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = PROD_W + AW;
   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       k_q, k_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [DATA_W-1:0]   line_q [TAPS];
   logic [DATA_W-1:0]   line_d [TAPS];

   logic [AW-1:0]       rd_idx;
   logic [DATA_W-1:0]   coef_rdata;
   logic                coef_wr_en;
   logic [ACC_W-1:0]    acc_shifted;
   logic                sat;

   fir_mac_sequencer_coef_bank #(.TAPS(TAPS)) u_coef_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (coef_wr_en),
      .waddr (coef_addr),
      .wdata (coef_wdata),
      .raddr (k_q),
      .rdata (coef_rdata)
   );

   // Tap k reads x[n-k]: walk backwards from the newest sample, wrapping modulo TAPS.
   always_comb begin
      if (wr_ptr_q >= k_q) begin
         rd_idx = wr_ptr_q - k_q;
      end else begin
         rd_idx = wr_ptr_q - k_q + AW'(TAPS);
      end
   end

   assign acc_shifted = acc_q >> SHIFT;
   assign sat         = |acc_shifted[ACC_W-1:DATA_W];

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and out_data/out_sat hold while out_valid is high and not taken.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      k_d        = k_q;
      acc_d      = acc_q;
      line_d     = line_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_sat    = 1'b0;
      mult_a     = '0;
      mult_b     = '0;
      coef_wr_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by rst_n so in_ready reads 0 while reset is held.
            in_ready   = rst_n;
            coef_wr_en = coef_we;
            if (in_valid) begin
               line_d[wr_ptr_q] = in_data;
               acc_d            = '0;
               k_d              = '0;
               state_d          = ST_MAC;
            end
         end
         ST_MAC: begin
            mult_a = line_q[rd_idx];
            mult_b = coef_rdata;
            acc_d  = acc_q + ACC_W'(mult_p);
            if (k_q == LAST) begin
               wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
               state_d  = ST_OUT;
            end else begin
               k_d = k_q + AW'(1);
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
            out_sat   = sat;
            out_data  = sat ? {DATA_W{1'b1}} : acc_shifted[DATA_W-1:0];
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         for (int i = 0; i < TAPS; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         line_q   <= line_d;
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (TAPS=8, SHIFT=16) with a behavioural multiplier.
module tb_fir_mac_sequencer;

   localparam int TAPS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [15:0] coef_wdata = '0;
   logic [15:0] mult_a, mult_b;
   logic [31:0] mult_p;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_sat;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      int          tid;
      logic [15:0] din;
      logic [15:0] exp_data;
      logic        exp_sat;
   } vec_t;
   vec_t vecs[$];

   fir_mac_sequencer #(.TAPS(TAPS), .SHIFT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_p     (mult_p),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sat    (out_sat)
   );

   assign mult_p = 32'(mult_a) * 32'(mult_b);

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] coef_val(input int pat, input int k);
      case (pat)
         1:       return 16'(k * 256);
         2:       return 16'h2000;
         3:       return 16'hFFFF;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  in_ready,  0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  out_data,  0);
      check({tag, "_out_sat"},   out_sat,   0);
      check({tag, "_mult_a"},    mult_a,    0);
      check({tag, "_mult_b"},    mult_b,    0);
   endtask

   // Enters and leaves at a falling edge with in_ready high.
   task automatic do_reset(input string tag);
      @(negedge clk);
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      check_all_zero(tag);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check({tag, "_ready_after_release"}, in_ready, 1);
   endtask

   task automatic load_coefs(input int pat);
      for (int k = 0; k < TAPS; k++) begin
         coef_we    = 1'b1;
         coef_addr  = 3'(k);
         coef_wdata = coef_val(pat, k);
         @(negedge clk);
      end
      coef_we = 1'b0;
   endtask

   // Offers one sample; returns one falling edge after acceptance (cycle 1).
   task automatic send(input logic [15:0] din, input string tag);
      int w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_in_ready_wait"}, (w < 40), 1);
      in_valid = 1'b1;
      in_data  = din;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for out_valid counting cycles from acceptance, compares, then completes the handshake.
   task automatic collect(input int start_lat, input logic exp_sat, input string tag);
      int lat = start_lat;
      logic [15:0] exp_d;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, TAPS + 1);
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check({tag, "_data"}, out_data, exp_d);
      check({tag, "_sat"},  out_sat,  exp_sat);
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_valid_drop"}, out_valid, 0);
   endtask

   task automatic run_vec(input logic [15:0] din, input logic [15:0] exp_d, input logic exp_sat,
                          input string tag);
      exp_q.push_back(exp_d);
      send(din, tag);
      collect(1, exp_sat, tag);
   endtask

   initial begin
      int cur;
      int highs;

      // tid 0: zero coefs; 1: impulse; 2: DC ramp; 3: saturation.
      vecs.push_back('{0, 16'd100, 16'd0, 1'b0});
      vecs.push_back('{1, 16'h8000, 16'h0000, 1'b0});
      for (int i = 1; i < 8; i++) vecs.push_back('{1, 16'h0000, 16'(i * 16'h80), 1'b0});
      for (int i = 1; i <= 10; i++)
         vecs.push_back('{2, 16'd1000, (i >= 8) ? 16'd1000 : 16'(125 * i), 1'b0});
      vecs.push_back('{3, 16'hFFFF, 16'hFFFE, 1'b0});
      for (int i = 2; i <= 8; i++) vecs.push_back('{3, 16'hFFFF, 16'hFFFF, 1'b1});

      cur = -1;
      foreach (vecs[i]) begin
         if (vecs[i].tid != cur) begin
            cur = vecs[i].tid;
            do_reset($sformatf("rst_t%0d", cur));
            load_coefs(cur);
         end
         run_vec(vecs[i].din, vecs[i].exp_data, vecs[i].exp_sat, $sformatf("t%0d_v%0d", cur, i));
      end

      // Backpressure: output held, input blocked, offered sample not taken.
      do_reset("rst_bp");
      load_coefs(2);
      out_ready = 1'b0;
      exp_q.push_back(16'd125);
      send(16'd1000, "bp");
      highs = 0;
      while (!out_valid && highs < 40) begin
         @(negedge clk);
         highs++;
      end
      check("bp_latency", highs + 1, TAPS + 1);
      check("bp_data_first", out_data, exp_q[0]);
      in_valid = 1'b1;
      in_data  = 16'd5000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp_valid_c%0d", c),    out_valid, 1);
         check($sformatf("bp_data_c%0d", c),     out_data,  16'd125);
         check($sformatf("bp_in_ready_c%0d", c), in_ready,  0);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      check("bp_valid_drop", out_valid, 0);
      check("bp_ready_back", in_ready,  1);
      run_vec(16'd1000, 16'd250, 1'b0, "bp_next");

      // Coefficient write during MAC is ignored.
      do_reset("rst_cw");
      load_coefs(2);
      exp_q.push_back(16'd125);
      send(16'd1000, "cw_a");
      coef_we    = 1'b1;
      coef_addr  = 3'd0;
      coef_wdata = 16'hFFFF;
      @(negedge clk);
      coef_we = 1'b0;
      collect(2, 1'b0, "cw_a");
      run_vec(16'd1000, 16'd250, 1'b0, "cw_b");

      // Coefficient written in the same cycle a sample is accepted applies to that sample.
      do_reset("rst_sc");
      in_valid   = 1'b1;
      in_data    = 16'd1000;
      coef_we    = 1'b1;
      coef_addr  = 3'd0;
      coef_wdata = 16'h2000;
      @(negedge clk);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      exp_q.push_back(16'd125);
      collect(1, 1'b0, "same_cycle");

      // Reset in the middle of MAC: no result, everything back to reset values.
      send(16'd2000, "mid");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      highs = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) highs++;
      end
      check("mid_no_valid", highs, 0);
      check("mid_ready", in_ready, 1);
      run_vec(16'd1000, 16'd0, 1'b0, "mid_coef_cleared");
      load_coefs(2);
      run_vec(16'd1000, 16'd250, 1'b0, "mid_second");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
